// File: rtl/id_stage_if.sv
// Bundles the fetch-side instruction, writeback, fetch-redirect and EX-issue
// signals of the decode stage.
interface id_stage_if;
  logic [15:0] id_instr;
  logic [15:0] id_instr_addr;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        STALL;
  logic        BRANCH;
  logic [15:0] branch_instr_addr;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [3:0]  ex_rd;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic [15:0] ex_imm;
  logic [15:0] ex_pc;

  modport master (
    output id_instr, id_instr_addr, wb_en, wb_reg, wb_data,
    input  STALL, BRANCH, branch_instr_addr,
    input  ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc
  );

  modport slave (
    input  id_instr, id_instr_addr, wb_en, wb_reg, wb_data,
    output STALL, BRANCH, branch_instr_addr,
    output ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: register file with write-through, busy scoreboard for hazard
// stalls, branch/jump resolution and post-redirect squash of wrong-path fetches.
module id_stage #(
    parameter int SQUASH_CYCLES = 2
) (
    input logic     CLOCK_50,
    input logic     reset,
    id_stage_if.slave bus
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LW   = 4'h6,
        OP_SW   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_JMP  = 4'h9
    } op_e;

    localparam int SQ_W = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

    logic [15:0]     regs [16];
    logic [15:0]     busy;
    logic [SQ_W-1:0] squash_cnt;

    logic [3:0]  op, rd, rs, rt;
    logic [15:0] imm4, rs_val, rt_val, rd_val, target;
    logic        reads_rs, reads_rt, reads_rd, writes_rd;
    logic        hazard, active, stall, take, issue;

    assign op   = bus.id_instr[15:12];
    assign rd   = bus.id_instr[11:8];
    assign rs   = bus.id_instr[7:4];
    assign rt   = bus.id_instr[3:0];
    assign imm4 = {{12{bus.id_instr[3]}}, bus.id_instr[3:0]};

    // Same-cycle writeback is forwarded so the read sees the value being written.
    function automatic logic [15:0] read_reg(input logic [3:0] idx);
        if (idx == 4'd0)
            return '0;
        else if (bus.wb_en && bus.wb_reg == idx)
            return bus.wb_data;
        else
            return regs[idx];
    endfunction

    function automatic logic pending(input logic [3:0] idx);
        return busy[idx] && !(bus.wb_en && bus.wb_reg == idx);
    endfunction

    assign rs_val = read_reg(rs);
    assign rt_val = read_reg(rt);
    assign rd_val = read_reg(rd);

    always_comb begin
        reads_rs  = (op >= OP_ADD) && (op <= OP_BEQ);
        reads_rt  = (op >= OP_ADD) && (op <= OP_OR);
        reads_rd  = (op == OP_SW) || (op == OP_BEQ);
        writes_rd = (op >= OP_ADD) && (op <= OP_LW);
        hazard    = (reads_rs && pending(rs)) ||
                    (reads_rt && pending(rt)) ||
                    ((reads_rd || writes_rd) && pending(rd));
        active    = !reset && (squash_cnt == '0);
        stall     = active && hazard;
        take      = active && !hazard &&
                    ((op == OP_JMP) || (op == OP_BEQ && rd_val == rs_val));
        issue     = active && !hazard && (op >= OP_ADD) && (op <= OP_SW);
        target    = (op == OP_JMP) ? {4'b0, bus.id_instr[11:0]}
                                   : bus.id_instr_addr + 16'd1 + imm4;
    end

    assign bus.STALL             = stall;
    assign bus.BRANCH            = take;
    assign bus.branch_instr_addr = take ? target : '0;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++)
                regs[i] <= '0;
            busy         <= '0;
            squash_cnt   <= '0;
            bus.ex_valid <= 1'b0;
            bus.ex_op    <= '0;
            bus.ex_rd    <= '0;
            bus.ex_a     <= '0;
            bus.ex_b     <= '0;
            bus.ex_imm   <= '0;
            bus.ex_pc    <= '0;
        end else begin
            if (bus.wb_en && bus.wb_reg != 4'd0)
                regs[bus.wb_reg] <= bus.wb_data;
            // Set after clear: a register re-issued in its own writeback cycle stays busy.
            if (bus.wb_en)
                busy[bus.wb_reg] <= 1'b0;
            if (issue && writes_rd && rd != 4'd0)
                busy[rd] <= 1'b1;

            if (take)
                squash_cnt <= SQ_W'(SQUASH_CYCLES);
            else if (squash_cnt != '0)
                squash_cnt <= squash_cnt - 1'b1;

            bus.ex_valid <= issue;
            if (issue) begin
                bus.ex_op  <= op;
                bus.ex_rd  <= (op == OP_SW) ? 4'd0 : rd;
                bus.ex_a   <= rs_val;
                bus.ex_b   <= (op == OP_SW) ? rd_val : rt_val;
                bus.ex_imm <= (op >= OP_ADDI) ? imm4 : '0;
                bus.ex_pc  <= bus.id_instr_addr;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed test of id_stage: stimulus pushes the expected EX-side result per cycle,
// a negedge monitor pops and compares; combinational outputs are checked inline.
module tb_id_stage;

    logic CLOCK_50;
    logic reset;

    id_stage_if ifc ();

    id_stage #(.SQUASH_CYCLES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ifc.slave)
    );

    typedef struct {
        logic        full;
        logic        valid;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc;
        int          id;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   stepno = 0;

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int id, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, got, want);
        end
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("ex_valid", e.id, {15'd0, ifc.ex_valid}, {15'd0, e.valid});
            if (e.full) begin
                chk("ex_op",  e.id, {12'd0, ifc.ex_op}, {12'd0, e.op});
                chk("ex_rd",  e.id, {12'd0, ifc.ex_rd}, {12'd0, e.rd});
                chk("ex_a",   e.id, ifc.ex_a,   e.a);
                chk("ex_b",   e.id, ifc.ex_b,   e.b);
                chk("ex_imm", e.id, ifc.ex_imm, e.imm);
                chk("ex_pc",  e.id, ifc.ex_pc,  e.pc);
            end
        end else if (ifc.ex_valid) begin
            chk("unexpected ex_valid", -1, {15'd0, ifc.ex_valid}, 16'd0);
        end
    end

    // One cycle: drive inputs, check STALL/BRANCH/target, queue the EX result due next edge.
    task automatic step(input logic rst, input logic [15:0] instr, input logic [15:0] addr,
                        input logic we, input logic [3:0] wr, input logic [15:0] wd,
                        input logic es, input logic eb, input logic [15:0] et,
                        input logic ev, input logic [3:0] eop, input logic [3:0] erd,
                        input logic [15:0] ea, input logic [15:0] ebv, input logic [15:0] eimm);
        exp_t e;
        stepno++;
        reset             = rst;
        ifc.id_instr      = instr;
        ifc.id_instr_addr = addr;
        ifc.wb_en         = we;
        ifc.wb_reg        = wr;
        ifc.wb_data       = wd;
        #1;
        chk("STALL",  stepno, {15'd0, ifc.STALL},  {15'd0, es});
        chk("BRANCH", stepno, {15'd0, ifc.BRANCH}, {15'd0, eb});
        if (eb || rst)
            chk("branch_instr_addr", stepno, ifc.branch_instr_addr, et);
        e.full  = ev || rst;
        e.valid = ev;
        e.op    = rst ? 4'd0 : eop;
        e.rd    = rst ? 4'd0 : erd;
        e.a     = rst ? 16'd0 : ea;
        e.b     = rst ? 16'd0 : ebv;
        e.imm   = rst ? 16'd0 : eimm;
        e.pc    = rst ? 16'd0 : addr;
        e.id    = stepno;
        sbq.push_back(e);
        @(negedge CLOCK_50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ifc.id_instr = '0;
        ifc.id_instr_addr = '0;
        ifc.wb_en = 1'b0;
        ifc.wb_reg = '0;
        ifc.wb_data = '0;
        @(negedge CLOCK_50);
        //   rst instr     addr     we wr  wdata    st br target   ev op rd  a        b        imm
        // reset with a JMP present and a writeback that must be ignored
        step(1, 16'h9ABC, 16'h0000, 1, 4, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(1, 16'h9ABC, 16'h0000, 1, 4, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        // ADDI R1,R0,5 then dependent ADD stalls until writeback of R1
        step(0, 16'h5105, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 1, 16'h0000, 16'h0000, 16'h0005);
        step(0, 16'h1211, 16'h0001, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h1211, 16'h0001, 1, 1, 16'h0005, 0, 0, 16'h0000, 1, 1, 2, 16'h0005, 16'h0005, 16'h0000);
        step(0, 16'h0000, 16'h0002, 1, 2, 16'h0007, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h0000, 16'h0003, 1, 1, 16'h0007, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        // AND R3,R4,R4: R4 must still be 0 (write during reset ignored)
        step(0, 16'h3344, 16'h0004, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 3, 16'h0000, 16'h0000, 16'h0000);
        // BEQ R1,R2 taken (7==7), then two squashed slots incl. JMP and a would-be stall
        step(0, 16'h8123, 16'h0010, 0, 0, 16'h0000, 0, 1, 16'h0014, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h9ABC, 16'h0011, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h1333, 16'h0012, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        // ADDI R4,R3,7 with same-cycle writeback R3=9
        step(0, 16'h5437, 16'h0014, 1, 3, 16'h0009, 0, 0, 16'h0000, 1, 5, 4, 16'h0009, 16'h0000, 16'h0007);
        // BEQ not taken (R1=7, R2=8 via bypass), next instruction issues
        step(0, 16'h8123, 16'h0015, 1, 2, 16'h0008, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h2121, 16'h0016, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 1, 16'h0008, 16'h0007, 16'h0000);
        // JMP taken, then JMP inside squash window ignored
        step(0, 16'h9ABC, 16'h0017, 0, 0, 16'h0000, 0, 1, 16'h0ABC, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h8123, 16'h0018, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h9ABC, 16'h0019, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        // write to R0 ignored
        step(0, 16'h0000, 16'h0ABC, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h1300, 16'h0ABD, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 3, 16'h0000, 16'h0000, 16'h0000);
        // SW on busy R4 stalls; reset aborts it; afterwards SW issues with bypassed R4
        step(0, 16'h7465, 16'h0ABE, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(1, 16'h7465, 16'h0ABE, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h7465, 16'h0ABE, 1, 4, 16'hBEEF, 0, 0, 16'h0000, 1, 7, 0, 16'h0000, 16'hBEEF, 16'h0005);
        // BEQ R0,R0 with imm -2 at address 0 wraps to 0xFFFF
        step(0, 16'h800E, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h0000, 16'h0001, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h0000, 16'h0002, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        // ADDI R5,R4,-8
        step(0, 16'h5548, 16'h0020, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 16'hBEEF, 16'h0000, 16'hFFF8);
        // op F is a bubble and must not mark R1 busy
        step(0, 16'hF123, 16'h0021, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h1611, 16'h0022, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 6, 16'h0000, 16'h0000, 16'h0000);
        // LW R7,[R5+1] stalls on R5, then issues with writeback bypass
        step(0, 16'h6751, 16'h0023, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step(0, 16'h6751, 16'h0023, 1, 5, 16'h0100, 0, 0, 16'h0000, 1, 6, 7, 16'h0100, 16'h0000, 16'h0001);
        step(0, 16'h0000, 16'h0024, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        #2;
        chk("scoreboard drained", 0, 16'(sbq.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
